net_backward: RTL and testbench

Output-layer backward pass for the single-layer sigmoid classifier. Given the forward outputs `y`, one-hot targets `t`, the input vector `x` and a learning rate `lr`, it computes the per-neuron error term, delta_j = (y_j − t_j)·y_j·(1 − y_j), in IEEE-754 single precision. It then streams the scaled weight gradients g[j][i] = lr·delta_j·x_i, one per handshake, to the weight-update writer. The bias gradient lr·delta_j is exposed as a parallel vector.

---
 rtl/net_backward_if.sv | 32 +++
 rtl/net_backward.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_net_backward.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/net_backward_if.sv
// Handshake/data bundle between net_backward and its caller / gradient consumer.
// Vectors are flat: element k of y/t/bgrad/x sits at [32k+31:32k].
interface net_backward_if #(
  parameter int I = 784,
  parameter int O = 10
);
  localparam int JW = (O > 1) ? $clog2(O) : 1;
  localparam int IW = (I > 1) ? $clog2(I) : 1;

  logic            start;
  logic [O*32-1:0] y;
  logic [O*32-1:0] t;
  logic [I*32-1:0] x;
  logic [31:0]     lr;
  logic [O*32-1:0] bgrad;
  logic            g_valid;
  logic            g_ready;
  logic [31:0]     g_data;
  logic [JW-1:0]   g_row;
  logic [IW-1:0]   g_col;
  logic            busy;
  logic            done;

  modport master (
    output start, y, t, x, lr, g_ready,
    input  bgrad, g_valid, g_data, g_row, g_col, busy, done
  );
  modport slave (
    input  start, y, t, x, lr, g_ready,
    output bgrad, g_valid, g_data, g_row, g_col, busy, done
  );
endinterface

// File: rtl/net_backward.sv
// Sigmoid output-layer backward pass: delta, lr-scaled bias gradient, streamed weight gradients.
// Optional NET_BACKWARD_SKIP_ZERO_EN: suppress beats whose x_i is +/-0.

// FP32 adder, round-to-nearest-even, denormals flushed to zero. start->done in 2 cycles.
module add_float (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] y
);
  logic [31:0] a_r, b_r, big, sml, res;
  logic        pend, za, zb, ia, ib, na, nb, sub, g, st;
  logic [7:0]  d;
  logic [49:0] bm, smf, sm, lost;
  logic [50:0] sum, norm;
  logic [5:0]  lz;
  logic [9:0]  ex;
  logic [23:0] man;
  logic [24:0] mr;

  function automatic logic [5:0] clz51(input logic [50:0] v);
    clz51 = 6'd51;
    for (int k = 0; k <= 50; k++) if (v[k]) clz51 = 6'(50 - k);
  endfunction

  always_comb begin
    za = (a_r[30:23] == 8'h00);
    zb = (b_r[30:23] == 8'h00);
    ia = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'h0);
    ib = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'h0);
    na = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'h0);
    nb = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'h0);
    if (a_r[30:0] >= b_r[30:0]) begin big = a_r; sml = b_r; end
    else                        begin big = b_r; sml = a_r; end
    d    = big[30:23] - sml[30:23];
    bm   = {1'b1, big[22:0], 26'b0};
    smf  = {1'b1, sml[22:0], 26'b0};
    lost = '0;
    // bits shifted out of the small operand collapse into a sticky jam at bit 0
    if (d >= 8'd50) sm = 50'd1;
    else begin
      sm    = smf >> d;
      lost  = smf << (6'd50 - d[5:0]);
      sm[0] = sm[0] | (|lost);
    end
    sub  = big[31] ^ sml[31];
    sum  = sub ? ({1'b0, bm} - {1'b0, sm}) : ({1'b0, bm} + {1'b0, sm});
    lz   = clz51(sum);
    norm = sum << lz;
    ex   = {2'b0, big[30:23]} + 10'd1 - {4'b0, lz};
    man  = norm[50:27];
    g    = norm[26];
    st   = |norm[25:0];
    mr   = {1'b0, man} + {24'b0, g & (st | man[0])};
    if (mr[24]) begin ex = ex + 10'd1; man = mr[24:1]; end
    else man = mr[23:0];

    if (na || nb || (ia && ib && (a_r[31] != b_r[31]))) res = 32'h7FC00000;
    else if (ia)                        res = a_r;
    else if (ib)                        res = b_r;
    else if (za && zb)                  res = {a_r[31] & b_r[31], 31'b0};
    else if (za)                        res = b_r;
    else if (zb)                        res = a_r;
    else if (sum == 51'd0)              res = 32'h0;
    else if ($signed(ex) >= 10'sd255)   res = {big[31], 8'hFF, 23'b0};
    else if ($signed(ex) <= 10'sd0)     res = {big[31], 31'b0};
    else                                res = {big[31], ex[7:0], man[22:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0; b_r <= '0; pend <= 1'b0; done <= 1'b0; y <= '0;
    end else begin
      pend <= start;
      done <= pend;
      if (start) begin a_r <= a; b_r <= b; end
      if (pend) y <= res;
    end
  end
endmodule

// FP32 multiplier, round-to-nearest-even, denormals flushed to zero. start->done in 2 cycles.
module mul_float (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] y
);
  logic [31:0] a_r, b_r, res;
  logic        pend, sgn, za, zb, ia, ib, na, nb, g, st;
  logic [47:0] prod;
  logic [9:0]  ex;
  logic [23:0] man;
  logic [24:0] mr;

  always_comb begin
    sgn  = a_r[31] ^ b_r[31];
    za   = (a_r[30:23] == 8'h00);
    zb   = (b_r[30:23] == 8'h00);
    ia   = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'h0);
    ib   = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'h0);
    na   = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'h0);
    nb   = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'h0);
    prod = {24'b0, 1'b1, a_r[22:0]} * {24'b0, 1'b1, b_r[22:0]};
    ex   = {2'b0, a_r[30:23]} + {2'b0, b_r[30:23]} - 10'd127;
    if (prod[47]) begin
      man = prod[47:24]; g = prod[23]; st = |prod[22:0]; ex = ex + 10'd1;
    end else begin
      man = prod[46:23]; g = prod[22]; st = |prod[21:0];
    end
    mr = {1'b0, man} + {24'b0, g & (st | man[0])};
    if (mr[24]) begin ex = ex + 10'd1; man = mr[24:1]; end
    else man = mr[23:0];

    if (na || nb || (ia && zb) || (ib && za)) res = 32'h7FC00000;
    else if (ia || ib)                        res = {sgn, 8'hFF, 23'b0};
    else if (za || zb)                        res = {sgn, 31'b0};
    else if ($signed(ex) >= 10'sd255)         res = {sgn, 8'hFF, 23'b0};
    else if ($signed(ex) <= 10'sd0)           res = {sgn, 31'b0};
    else                                      res = {sgn, ex[7:0], man[22:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0; b_r <= '0; pend <= 1'b0; done <= 1'b0; y <= '0;
    end else begin
      pend <= start;
      done <= pend;
      if (start) begin a_r <= a; b_r <= b; end
      if (pend) y <= res;
    end
  end
endmodule

module net_backward #(
  parameter int I = 784,
  parameter int O = 10
) (
  input logic           clk,
  input logic           rst,
  net_backward_if.slave bus
);
  localparam int JW = (O > 1) ? $clog2(O) : 1;
  localparam int IW = (I > 1) ? $clog2(I) : 1;
  localparam logic [31:0] ONE = 32'h3F800000;

  typedef enum logic [3:0] {IDLE, D_SUB, D_OMY, D_P, D_D, D_LR, G_MUL, G_OUT, DONE} state_t;
  state_t state, state_n;

  logic                fresh, enter, adv;
  logic [JW-1:0]       j;
  logic [IW-1:0]       i;
  logic [O-1:0][31:0]  y_r, t_r, bg_r;
  logic [I-1:0][31:0]  x_a;
  logic [31:0]         lr_r, e_r, s_r, p_r, d_r, gd_r;
  logic [31:0]         y_j, t_j, x_i, op_a, op_b, add_y, mul_y;
  logic                add_go, mul_go, add_done, mul_done, skip, last_j, last_i;

  assign x_a    = bus.x;
  assign y_j    = y_r[j];
  assign t_j    = t_r[j];
  assign x_i    = x_a[i];
  assign last_j = (j == JW'(O - 1));
  assign last_i = (i == IW'(I - 1));

`ifdef NET_BACKWARD_SKIP_ZERO_EN
  assign skip = (x_i[30:0] == 31'h0);
`else
  assign skip = 1'b0;
`endif

  // fresh marks the first cycle of a state; float units are kicked only then
  assign add_go = fresh && (state == D_SUB || state == D_OMY);
  assign mul_go = fresh && (state == D_P || state == D_D || state == D_LR ||
                            (state == G_MUL && !skip));

  // Units never overlap, so a single operand bus feeds both.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      D_SUB: begin op_a = y_j;  op_b = {~t_j[31], t_j[30:0]}; end
      D_OMY: begin op_a = ONE;  op_b = {~y_j[31], y_j[30:0]}; end
      D_P:   begin op_a = y_j;  op_b = s_r;  end
      D_D:   begin op_a = e_r;  op_b = p_r;  end
      D_LR:  begin op_a = lr_r; op_b = d_r;  end
      G_MUL: begin op_a = bg_r[j]; op_b = x_i; end
      default: ;
    endcase
  end

  add_float u_add (.clk(clk), .rst(rst), .start(add_go), .a(op_a), .b(op_b),
                   .done(add_done), .y(add_y));
  mul_float u_mul (.clk(clk), .rst(rst), .start(mul_go), .a(op_a), .b(op_b),
                   .done(mul_done), .y(mul_y));

  always_comb begin
    state_n = state;
    enter   = 1'b0;
    adv     = 1'b0;
    case (state)
      IDLE:  if (bus.start) begin state_n = D_SUB; enter = 1'b1; end
      D_SUB: if (add_done)  begin state_n = D_OMY; enter = 1'b1; end
      D_OMY: if (add_done)  begin state_n = D_P;   enter = 1'b1; end
      D_P:   if (mul_done)  begin state_n = D_D;   enter = 1'b1; end
      D_D:   if (mul_done)  begin state_n = D_LR;  enter = 1'b1; end
      D_LR:  if (mul_done)  begin state_n = last_j ? G_MUL : D_SUB; enter = 1'b1; end
      G_MUL: begin
        if (fresh && skip) begin
          adv     = 1'b1;
          state_n = (last_j && last_i) ? DONE : G_MUL;
          enter   = 1'b1;
        end else if (mul_done) begin
          state_n = G_OUT;
          enter   = 1'b1;
        end
      end
      G_OUT: if (bus.g_ready) begin
        adv     = 1'b1;
        state_n = (last_j && last_i) ? DONE : G_MUL;
        enter   = 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fresh <= 1'b0;
      j     <= '0;
      i     <= '0;
      y_r   <= '0;
      t_r   <= '0;
      bg_r  <= '0;
      lr_r  <= '0;
      e_r   <= '0;
      s_r   <= '0;
      p_r   <= '0;
      d_r   <= '0;
      gd_r  <= '0;
    end else begin
      state <= state_n;
      fresh <= enter;
      case (state)
        IDLE: if (bus.start) begin
          y_r  <= bus.y;
          t_r  <= bus.t;
          lr_r <= bus.lr;
          j    <= '0;
          i    <= '0;
        end
        D_SUB: if (add_done) e_r <= add_y;
        D_OMY: if (add_done) s_r <= add_y;
        D_P:   if (mul_done) p_r <= mul_y;
        D_D:   if (mul_done) d_r <= mul_y;
        D_LR:  if (mul_done) begin
          bg_r[j] <= mul_y;
          j       <= last_j ? '0 : j + 1'b1;
        end
        G_MUL: if (mul_done) gd_r <= mul_y;
        default: ;
      endcase
      // row-major walk over the gradient matrix
      if (adv) begin
        i <= last_i ? '0 : i + 1'b1;
        if (last_i) j <= last_j ? '0 : j + 1'b1;
      end
    end
  end

  assign bus.bgrad   = bg_r;
  assign bus.g_valid = (state == G_OUT);
  assign bus.g_data  = gd_r;
  assign bus.g_row   = j;
  assign bus.g_col   = i;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
endmodule

// File: tb/tb_net_backward.sv
// Randomized self-checking bench for net_backward against a real-arithmetic reference model.
module tb_net_backward;
  localparam int O = 2;
  localparam int I = 4;
  localparam logic [31:0] ONE = 32'h3F800000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  net_backward_if #(.I(I), .O(O)) bus ();
  net_backward #(.I(I), .O(O)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic [31:0] ym[O], tm[O], xm[I], lrm;
  logic [31:0] bexp[O];
  typedef struct packed { logic [31:0] d; logic [7:0] r; logic [7:0] c; } beat_t;
  beat_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // float <-> real, denormals treated as zero, round-to-nearest-even on the way back
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    if (f[30:23] == 8'h00) b = {f[31], 63'b0};
    else b = {f[31], {3'b0, f[30:23]} + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    int          fe;
    logic [23:0] m;
    logic [24:0] mr;
    logic        g, st;
    b = $realtobits(r);
    if (b[62:52] == 11'h0) return {b[63], 31'b0};
    fe = int'(b[62:52]) - 896;
    m  = {1'b1, b[51:29]};
    g  = b[28];
    st = |b[27:0];
    mr = {1'b0, m} + 25'(g && (st || m[0]));
    if (mr[24]) begin fe++; m = mr[24:1]; end
    else m = mr[23:0];
    if (fe >= 255) return {b[63], 8'hFF, 23'b0};
    if (fe <= 0) return {b[63], 31'b0};
    return {b[63], fe[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) - f2r(b));
  endfunction
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  task automatic build_model();
    logic [31:0] e, s, p, d;
    q.delete();
    for (int j = 0; j < O; j++) begin
      e = fsub(ym[j], tm[j]);
      s = fsub(ONE, ym[j]);
      p = fmul(ym[j], s);
      d = fmul(e, p);
      bexp[j] = fmul(lrm, d);
    end
    for (int j = 0; j < O; j++)
      for (int i = 0; i < I; i++) begin
`ifdef NET_BACKWARD_SKIP_ZERO_EN
        if (xm[i][30:0] == 31'h0) continue;
`endif
        q.push_back('{d: fmul(bexp[j], xm[i]), r: 8'(j), c: 8'(i)});
      end
  endtask

  task automatic load();
    for (int j = 0; j < O; j++) begin
      bus.y[32*j +: 32] = ym[j];
      bus.t[32*j +: 32] = tm[j];
    end
    for (int i = 0; i < I; i++) bus.x[32*i +: 32] = xm[i];
    bus.lr = lrm;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // one full operation; stall holds g_ready low 10 cycles on the first beat,
  // poke re-asserts start during DELTA and during DONE
  task automatic run(input int rdy_pct, input bit stall, input bit poke, output logic [31:0] first_d);
    int    cyc, stall_left;
    bit    got_done, held, first;
    logic [63:0] snap, cur;
    beat_t e;
    load();
    build_model();
    pulse_start();
    chk("busy_rise", 64'(bus.busy), 64'd1);
    cyc = 0; got_done = 0; held = 0; first = 1; first_d = '0; snap = '0;
    stall_left = stall ? 10 : 0;
    while (cyc < 3000) begin
      if (bus.done) begin got_done = 1; break; end
      if (stall_left > 0 && bus.g_valid) begin
        bus.g_ready = 1'b0;
        stall_left--;
      end else bus.g_ready = ($urandom_range(99) < rdy_pct);
      cur = {bus.g_data, 16'(bus.g_row), 16'(bus.g_col)};
      if (held) begin
        chk("valid_held", 64'(bus.g_valid), 64'd1);
        chk("beat_stable", cur, snap);
      end
      if (bus.g_valid && bus.g_ready) begin
        chk("beat_avail", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("beat_data", 64'(bus.g_data), 64'(e.d));
          chk("beat_row", 64'(bus.g_row), 64'(e.r));
          chk("beat_col", 64'(bus.g_col), 64'(e.c));
        end
        if (first) begin first_d = bus.g_data; first = 0; end
      end
      held = bus.g_valid && !bus.g_ready;
      snap = cur;
      bus.start = (poke && cyc == 3);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("done_seen", 64'(got_done), 64'd1);
    chk("beats_left", 64'(q.size()), 64'd0);
    if (poke) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_pulse", 64'(bus.done), 64'd0);
    chk("busy_fall", 64'(bus.busy), 64'd0);
    for (int j = 0; j < O; j++) chk($sformatf("bgrad%0d", j), 64'(bus.bgrad[32*j +: 32]), 64'(bexp[j]));
  endtask

  task automatic run_reset_mid();
    int cyc, nb;
    load();
    pulse_start();
    bus.g_ready = 1'b1;
    cyc = 0; nb = 0;
    while (nb < 2 && cyc < 3000) begin
      if (bus.g_valid) nb++;
      @(negedge clk);
      cyc++;
    end
    chk("two_beats_before_rst", 64'(nb), 64'd2);
    rst = 1'b1;
    #1;
    chk("rst_gvalid", 64'(bus.g_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_bgrad", 64'(bus.bgrad), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_unit();
    return {1'b0, 8'(123 + $urandom_range(3)), 23'($urandom)};
  endfunction

  task automatic randomize_vec();
    int hot;
    hot = $urandom_range(O - 1);
    for (int j = 0; j < O; j++) begin
      tm[j] = (j == hot) ? ONE : 32'h0;
      case ($urandom_range(5))
        0:       ym[j] = tm[j];
        1:       ym[j] = ONE;
        default: ym[j] = rnd_unit();
      endcase
    end
    for (int i = 0; i < I; i++)
      xm[i] = ($urandom_range(3) == 0) ? {1'($urandom), 31'b0}
                                       : {1'($urandom), 8'(123 + $urandom_range(5)), 23'($urandom)};
    lrm = {1'b0, 8'(119 + $urandom_range(7)), 23'($urandom)};
  endtask

  initial begin
    logic [31:0] fd;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.g_ready = 1'b0;
    bus.y = '0; bus.t = '0; bus.x = '0; bus.lr = '0;
    repeat (2) @(negedge clk);
    chk("rst_state_gvalid", 64'(bus.g_valid), 64'd0);
    chk("rst_state_gdata", 64'(bus.g_data), 64'd0);
    chk("rst_state_rowcol", 64'({bus.g_row, bus.g_col}), 64'd0);
    chk("rst_state_bgrad", 64'(bus.bgrad), 64'd0);
    chk("rst_state_busy", 64'(bus.busy), 64'd0);
    chk("rst_state_done", 64'(bus.done), 64'd0);
    rst = 1'b0;

    // known vector: neuron 0 gives -0.125 / -0.25, neuron 1 has y == t
    ym = '{32'h3F000000, 32'h3E800000};
    tm = '{ONE, 32'h3E800000};
    xm = '{32'h40000000, 32'h00000000, 32'h80000000, 32'hC0400000};
    lrm = ONE;
    run(100, 0, 0, fd);
    chk("bgrad0_const", 64'(bus.bgrad[31:0]), 64'h00000000BE000000);
    chk("beat0_const", 64'(fd), 64'h00000000BE800000);
    chk("bgrad1_zero", 64'(bus.bgrad[62:32]), 64'd0);

    // zero-x pattern: under skip only cols 1 and 3 are emitted
    xm = '{32'h00000000, 32'h40000000, 32'h80000000, ONE};
    run(70, 0, 0, fd);

    // y == t everywhere
    randomize_vec();
    for (int j = 0; j < O; j++) ym[j] = tm[j];
    run(60, 0, 0, fd);

    randomize_vec();
    run(100, 1, 0, fd);

    randomize_vec();
    run(80, 0, 1, fd);

    randomize_vec();
    run_reset_mid();
    run(100, 0, 0, fd);

    for (int n = 0; n < 6; n++) begin
      randomize_vec();
      run(50, 0, 0, fd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
